// File: rtl/bcd_time_counter.sv
// BCD HH:MM:SS time-of-day counter with prescaled tick, validated load and carry pulses.
// Optional alarm comparator is enabled by defining BCD_TIME_COUNTER_ALARM_EN.
module bcd_time_counter #(
    parameter int unsigned FORMAT_24H = 1,
    parameter int unsigned TICK_DIV   = 1,
    parameter logic [23:0] INIT_TIME  = 24'h000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        run,
    input  logic        load,
    input  logic [23:0] load_time,
    input  logic        load_pm,
`ifdef BCD_TIME_COUNTER_ALARM_EN
    input  logic [23:0] alarm_time,
    input  logic        alarm_pm,
    input  logic        alarm_arm,
    input  logic        alarm_ack,
    output logic        alarm,
`endif
    output logic [23:0] time_bcd,
    output logic        pm,
    output logic        sec_pulse,
    output logic        day_pulse,
    output logic        load_err
);

    localparam int          PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam bit          MODE_24  = (FORMAT_24H != 0);
    // A 12-hour clock has no hour 00; it is shown as 12.
    localparam logic [23:0] INIT_MAPPED = (!MODE_24 && INIT_TIME[23:16] == 8'h00) ?
                                          {8'h12, INIT_TIME[15:0]} : INIT_TIME;

    logic [PW-1:0] pre_r;
    logic [23:0]   next_time_s;
    logic [7:0]    hours_s;
    logic          next_pm_s;
    logic          day_wrap_s;

    function automatic logic time_valid(input logic [23:0] t, input logic mode24);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (t[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        if (t[7:4] > 4'd5 || t[15:12] > 4'd5) ok = 1'b0;
        // With every digit already <= 9, packed BCD orders like binary.
        if (mode24) begin
            if (t[23:16] > 8'h23) ok = 1'b0;
        end else begin
            if (t[23:16] == 8'h00 || t[23:16] > 8'h12) ok = 1'b0;
        end
        return ok;
    endfunction

    // Time one second ahead of the current value, with digit carry chain and hour wrap
    always_comb begin
        next_time_s = time_bcd;
        next_pm_s   = pm;
        day_wrap_s  = 1'b0;
        hours_s     = time_bcd[23:16];
        if (time_bcd[3:0] != 4'd9) begin
            next_time_s[3:0] = time_bcd[3:0] + 4'd1;
        end else begin
            next_time_s[3:0] = 4'd0;
            if (time_bcd[7:4] != 4'd5) begin
                next_time_s[7:4] = time_bcd[7:4] + 4'd1;
            end else begin
                next_time_s[7:4] = 4'd0;
                if (time_bcd[11:8] != 4'd9) begin
                    next_time_s[11:8] = time_bcd[11:8] + 4'd1;
                end else begin
                    next_time_s[11:8] = 4'd0;
                    if (time_bcd[15:12] != 4'd5) begin
                        next_time_s[15:12] = time_bcd[15:12] + 4'd1;
                    end else begin
                        next_time_s[15:12] = 4'd0;
                        if (MODE_24) begin
                            if (hours_s == 8'h23) begin
                                hours_s    = 8'h00;
                                day_wrap_s = 1'b1;
                            end else if (hours_s[3:0] == 4'd9) begin
                                hours_s = {hours_s[7:4] + 4'd1, 4'd0};
                            end else begin
                                hours_s = {hours_s[7:4], hours_s[3:0] + 4'd1};
                            end
                        end else begin
                            if (hours_s == 8'h12) begin
                                hours_s = 8'h01;
                            end else if (hours_s == 8'h11) begin
                                // Noon or midnight: the day ends only leaving PM.
                                hours_s    = 8'h12;
                                next_pm_s  = ~pm;
                                day_wrap_s = pm;
                            end else if (hours_s[3:0] == 4'd9) begin
                                hours_s = 8'h10;
                            end else begin
                                hours_s = {hours_s[7:4], hours_s[3:0] + 4'd1};
                            end
                        end
                        next_time_s[23:16] = hours_s;
                    end
                end
            end
        end
    end

    // Time, prescaler and pulse registers: reset > load > count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            time_bcd  <= INIT_MAPPED;
            pm        <= 1'b0;
            pre_r     <= '0;
            sec_pulse <= 1'b0;
            day_pulse <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            sec_pulse <= 1'b0;
            day_pulse <= 1'b0;
            load_err  <= 1'b0;
            if (load) begin
                if (time_valid(load_time, MODE_24)) begin
                    time_bcd <= load_time;
                    pm       <= MODE_24 ? 1'b0 : load_pm;
                    pre_r    <= '0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (run && tick) begin
                if (pre_r == PRE_LAST) begin
                    pre_r     <= '0;
                    time_bcd  <= next_time_s;
                    pm        <= next_pm_s;
                    sec_pulse <= 1'b1;
                    day_pulse <= day_wrap_s;
                end else begin
                    pre_r <= pre_r + PW'(1);
                end
            end else begin
                pre_r <= pre_r;
            end
        end
    end

`ifdef BCD_TIME_COUNTER_ALARM_EN
    // Alarm latches the cycle after a matching second boundary; set beats ack
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alarm <= 1'b0;
        end else if (sec_pulse && alarm_arm && time_bcd == alarm_time &&
                     (MODE_24 || pm == alarm_pm)) begin
            alarm <= 1'b1;
        end else if (alarm_ack) begin
            alarm <= 1'b0;
        end else begin
            alarm <= alarm;
        end
    end
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Scoreboard bench for bcd_time_counter: three instances (24h/div1, 24h/div4, 12h/div1).
module tb_bcd_time_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0, tick = 1'b0, run = 1'b1, load = 1'b0, load_pm = 1'b0;
    logic [23:0] load_time = 24'h000000;
    logic [23:0] t_a, t_b, t_c;
    logic        pm_a, pm_b, pm_c, sp_a, sp_b, sp_c, dp_a, dp_b, dp_c, le_a, le_b, le_c;
`ifdef BCD_TIME_COUNTER_ALARM_EN
    logic [23:0] alarm_time = 24'h000000;
    logic        alarm_pm = 1'b0, alarm_arm = 1'b0, alarm_ack = 1'b0;
    logic        al_a, al_b, al_c;
`endif

    bcd_time_counter #(.FORMAT_24H(1), .TICK_DIV(1), .INIT_TIME(24'h235958)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .load(load),
        .load_time(load_time), .load_pm(load_pm),
`ifdef BCD_TIME_COUNTER_ALARM_EN
        .alarm_time(alarm_time), .alarm_pm(alarm_pm), .alarm_arm(alarm_arm),
        .alarm_ack(alarm_ack), .alarm(al_a),
`endif
        .time_bcd(t_a), .pm(pm_a), .sec_pulse(sp_a), .day_pulse(dp_a), .load_err(le_a));

    bcd_time_counter #(.FORMAT_24H(1), .TICK_DIV(4), .INIT_TIME(24'h000000)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .load(load),
        .load_time(load_time), .load_pm(load_pm),
`ifdef BCD_TIME_COUNTER_ALARM_EN
        .alarm_time(alarm_time), .alarm_pm(alarm_pm), .alarm_arm(alarm_arm),
        .alarm_ack(alarm_ack), .alarm(al_b),
`endif
        .time_bcd(t_b), .pm(pm_b), .sec_pulse(sp_b), .day_pulse(dp_b), .load_err(le_b));

    bcd_time_counter #(.FORMAT_24H(0), .TICK_DIV(1), .INIT_TIME(24'h000000)) dut_c (
        .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .load(load),
        .load_time(load_time), .load_pm(load_pm),
`ifdef BCD_TIME_COUNTER_ALARM_EN
        .alarm_time(alarm_time), .alarm_pm(alarm_pm), .alarm_arm(alarm_arm),
        .alarm_ack(alarm_ack), .alarm(al_c),
`endif
        .time_bcd(t_c), .pm(pm_c), .sec_pulse(sp_c), .day_pulse(dp_c), .load_err(le_c));

    typedef struct packed {
        logic        rst;
        logic        rn;
        logic        tk;
        logic        ld;
        logic [23:0] lt;
        logic        lp;
    } stim_t;

    int          applied = 0;
    int          miscompares = 0;
    stim_t       stim_q[$];
    logic [27:0] exp_q[$];

    function automatic logic [27:0] obs(input int w);
        case (w)
            0:       return {t_a, pm_a, sp_a, dp_a, le_a};
            1:       return {t_b, pm_b, sp_b, dp_b, le_b};
            2:       return {t_c, pm_c, sp_c, dp_c, le_c};
            default: return 28'h0;
        endcase
    endfunction

    task automatic add(input logic rst, rn, tk, ld, input logic [23:0] lt, input logic lp,
                       input logic [23:0] t, input logic p, s, d, e);
        stim_q.push_back({rst, rn, tk, ld, lt, lp});
        exp_q.push_back({t, p, s, d, e});
    endtask

    task automatic add_tick(input logic [23:0] t, input logic p, s, d);
        add(1'b1, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0, t, p, s, d, 1'b0);
    endtask

    task automatic add_load(input logic [23:0] lt, input logic lp,
                            input logic [23:0] t, input logic p, e);
        add(1'b1, 1'b1, 1'b0, 1'b1, lt, lp, t, p, 1'b0, 1'b0, e);
    endtask

    task automatic cyc(input stim_t s);
        rst_n = s.rst; run = s.rn; tick = s.tk; load = s.ld; load_time = s.lt; load_pm = s.lp;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [27:0] e, g;
        exp_q.push_back({24'h235958, 4'b0000});
        exp_q.push_back({24'h000000, 4'b0000});
        exp_q.push_back({24'h120000, 4'b0000});
        cyc({1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0});
        cyc({1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0});
        for (int w = 0; w < 3; w++) begin
            e = exp_q.pop_front();
            g = obs(w);
            applied++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL reset[%0d]: got %h/%b required %h/%b", w, g[27:4], g[3:0], e[27:4], e[3:0]);
            end
        end
    endtask

    task automatic test_rollover();
        logic [27:0] e, g;
        add_tick(24'h235959, 1'b0, 1'b1, 1'b0);
        add_tick(24'h000000, 1'b0, 1'b1, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);
        while (stim_q.size() > 0) begin
            cyc(stim_q.pop_front());
            e = exp_q.pop_front();
            g = obs(0);
            applied++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL rollover: got %h/%b required %h/%b", g[27:4], g[3:0], e[27:4], e[3:0]);
            end
        end
    endtask

    task automatic test_prescale();
        logic [27:0] e, g;
        add(1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++)
            add_tick((k >= 8) ? 24'h000002 : (k >= 4) ? 24'h000001 : 24'h000000,
                     1'b0, (k % 4) == 0, 1'b0);
        for (int k = 0; k < 3; k++)
            add(1'b1, 1'b0, 1'b1, 1'b0, 24'h0, 1'b0, 24'h000002, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) add_tick(24'h000002, 1'b0, 1'b0, 1'b0);
        add_tick(24'h000003, 1'b0, 1'b1, 1'b0);
        while (stim_q.size() > 0) begin
            cyc(stim_q.pop_front());
            e = exp_q.pop_front();
            g = obs(1);
            applied++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL prescale: got %h/%b required %h/%b", g[27:4], g[3:0], e[27:4], e[3:0]);
            end
        end
    endtask

    task automatic test_12h();
        logic [27:0] e, g;
        add_load(24'h115959, 1'b0, 24'h115959, 1'b0, 1'b0);
        add_tick(24'h120000, 1'b1, 1'b1, 1'b0);
        add_load(24'h125959, 1'b1, 24'h125959, 1'b1, 1'b0);
        add_tick(24'h010000, 1'b1, 1'b1, 1'b0);
        add_load(24'h115959, 1'b1, 24'h115959, 1'b1, 1'b0);
        add_tick(24'h120000, 1'b0, 1'b1, 1'b1);
        add_load(24'h095959, 1'b1, 24'h095959, 1'b1, 1'b0);
        add_tick(24'h100000, 1'b1, 1'b1, 1'b0);
        while (stim_q.size() > 0) begin
            cyc(stim_q.pop_front());
            e = exp_q.pop_front();
            g = obs(2);
            applied++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL mode12: got %h/%b required %h/%b", g[27:4], g[3:0], e[27:4], e[3:0]);
            end
        end
    endtask

    task automatic test_load();
        logic [27:0] e, g;
        int          w;
        add(1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h235958, 1'b0, 1'b0, 1'b0, 1'b0);
        add_load(24'h246000, 1'b0, 24'h235958, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h235958, 1'b0, 1'b0, 1'b0, 1'b0);
        add_load(24'h000000, 1'b0, 24'h120000, 1'b0, 1'b1);
        add_tick(24'h000000, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 24'h095959, 1'b0, 24'h095959, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) add_tick(24'h095959, 1'b0, 1'b0, 1'b0);
        add_tick(24'h100000, 1'b0, 1'b1, 1'b0);
        // Entries 0-2 observe dut_a, entry 3 dut_c, the rest dut_b.
        for (int n = 0; stim_q.size() > 0; n++) begin
            w = (n < 3) ? 0 : (n == 3) ? 2 : 1;
            cyc(stim_q.pop_front());
            e = exp_q.pop_front();
            g = obs(w);
            applied++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL load[%0d]: got %h/%b required %h/%b", n, g[27:4], g[3:0], e[27:4], e[3:0]);
            end
        end
    endtask

    task automatic test_carry();
        logic [27:0] e, g;
        add_load(24'h095959, 1'b0, 24'h095959, 1'b0, 1'b0);
        add_tick(24'h100000, 1'b0, 1'b1, 1'b0);
        add_load(24'h195959, 1'b0, 24'h195959, 1'b0, 1'b0);
        add_tick(24'h200000, 1'b0, 1'b1, 1'b0);
        add_load(24'h123456, 1'b0, 24'h123456, 1'b0, 1'b0);
        add_tick(24'h123457, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 24'h235958, 1'b0, 1'b0, 1'b0, 1'b0);
        while (stim_q.size() > 0) begin
            cyc(stim_q.pop_front());
            e = exp_q.pop_front();
            g = obs(0);
            applied++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL carry: got %h/%b required %h/%b", g[27:4], g[3:0], e[27:4], e[3:0]);
            end
        end
    endtask

`ifdef BCD_TIME_COUNTER_ALARM_EN
    task automatic test_alarm();
        logic [27:0] e, g;
        logic        al_q[$], ack_q[$];
        logic        ea;
        alarm_arm = 1'b1; alarm_time = 24'h000003; alarm_pm = 1'b0;
        add_load(24'h000000, 1'b0, 24'h000000, 1'b0, 1'b0);   al_q.push_back(1'b0); ack_q.push_back(1'b0);
        add_tick(24'h000001, 1'b0, 1'b1, 1'b0);                al_q.push_back(1'b0); ack_q.push_back(1'b0);
        add_tick(24'h000002, 1'b0, 1'b1, 1'b0);                al_q.push_back(1'b0); ack_q.push_back(1'b0);
        add_tick(24'h000003, 1'b0, 1'b1, 1'b0);                al_q.push_back(1'b0); ack_q.push_back(1'b0);
        for (int k = 0; k < 2; k++) begin
            add(1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h000003, 1'b0, 1'b0, 1'b0, 1'b0);
            al_q.push_back(1'b1); ack_q.push_back(1'b0);
        end
        add(1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h000003, 1'b0, 1'b0, 1'b0, 1'b0);
        al_q.push_back(1'b0); ack_q.push_back(1'b1);
        add_load(24'h000003, 1'b0, 24'h000003, 1'b0, 1'b0);   al_q.push_back(1'b0); ack_q.push_back(1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h000003, 1'b0, 1'b0, 1'b0, 1'b0);
        al_q.push_back(1'b0); ack_q.push_back(1'b0);
        while (stim_q.size() > 0) begin
            alarm_ack = ack_q.pop_front();
            cyc(stim_q.pop_front());
            e  = exp_q.pop_front();
            ea = al_q.pop_front();
            g  = obs(0);
            applied++;
            if (g !== e || al_a !== ea) begin
                miscompares++;
                $display("FAIL alarm: got %h/%b alarm=%b required %h/%b alarm=%b",
                         g[27:4], g[3:0], al_a, e[27:4], e[3:0], ea);
            end
        end
        alarm_ack = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_rollover();
        test_prescale();
        test_12h();
        test_load();
        test_carry();
`ifdef BCD_TIME_COUNTER_ALARM_EN
        test_alarm();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
